// File: rtl/alu_pipe_pkg.sv
// rtl/alu_pipe_pkg.sv - shared types, widths and the clamp/wrap helper for alu_pipe
package alu_pipe_pkg;

    typedef enum logic [1:0] {
        OP_LIN = 2'b00,
        OP_ADD = 2'b01,
        OP_ACC = 2'b10,
        OP_CLR = 2'b11
    } alu_op_e;

    // Product keeps one guard bit (W+1); the three-term sum keeps three (W+3).
    localparam int PROD_GUARD = 1;
    localparam int SUM_GUARD  = 3;
    localparam int CLAMP_W    = 64;

    typedef struct packed {
        logic                      sat;
        logic signed [CLAMP_W-1:0] val;
    } clamp_t;

    // Reduce a wide signed value to w bits, either clamping or wrapping.
    function automatic clamp_t sat_clamp(input logic signed [CLAMP_W-1:0] y,
                                         input int unsigned w,
                                         input logic sat_en);
        clamp_t                    r;
        logic signed [CLAMP_W-1:0] max_v;
        logic signed [CLAMP_W-1:0] min_v;
        logic signed [CLAMP_W-1:0] wrapped;
        max_v   = (64'sd1 <<< (w - 1)) - 64'sd1;
        min_v   = -(64'sd1 <<< (w - 1));
        wrapped = (y <<< (CLAMP_W - w)) >>> (CLAMP_W - w);
        r.val   = y;
        r.sat   = 1'b0;
        if (sat_en) begin
            if (y > max_v) begin
                r.val = max_v;
                r.sat = 1'b1;
            end else if (y < min_v) begin
                r.val = min_v;
                r.sat = 1'b1;
            end
        end else begin
            r.val = wrapped;
            r.sat = (wrapped != y);
        end
        return r;
    endfunction

endpackage

// File: rtl/alu_pipe_if.sv
// rtl/alu_pipe_if.sv - operation/result handshake bundle between decode and writeback
interface alu_pipe_if #(
    parameter int W = 8
);
    logic                in_valid;
    logic                in_ready;
    logic [1:0]          op;
    logic signed [W-1:0] a;
    logic signed [W-1:0] b;
    logic signed [W-1:0] ca;
    logic signed [W-1:0] cb;
    logic signed [W-1:0] e;
    logic                out_valid;
    logic                out_ready;
    logic signed [W-1:0] result;
    logic                sat;

    modport master (
        output in_valid, op, a, b, ca, cb, e, out_ready,
        input  in_ready, out_valid, result, sat
    );

    modport slave (
        input  in_valid, op, a, b, ca, cb, e, out_ready,
        output in_ready, out_valid, result, sat
    );
endinterface

// File: rtl/alu_pipe_scale_mult.sv
// rtl/alu_pipe_scale_mult.sv - signed integer times Q0.(W-1) coefficient, floored to W+1 bits
module alu_pipe_scale_mult #(
    parameter int W = 8
) (
    input  logic signed [W-1:0] x,
    input  logic signed [W-1:0] c,
    output logic signed [W:0]   p
);
    logic signed [2*W-1:0] prod;
    logic                  unused_frac;

    assign prod = (2*W)'(x) * (2*W)'(c);
    // Dropping the W-1 fraction bits of a two's-complement product floors toward -inf.
    assign p           = prod[2*W-1:W-1];
    assign unused_frac = ^prod[W-2:0];
endmodule

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - pipelined a*ca + b*cb + e ALU with accumulator, saturation and handshake
module alu_pipe
    import alu_pipe_pkg::*;
#(
    parameter int BUS_WIDTH = 8,
    parameter bit SAT_EN    = 1'b1
) (
    input logic     clk,
    input logic     rst,
    alu_pipe_if.slave bus
);
    localparam int W  = BUS_WIDTH;
    localparam int PW = W + PROD_GUARD;
    localparam int SW = W + SUM_GUARD;

    logic                 stall;
    logic                 adv;

    logic                 s1_valid;
    alu_op_e              s1_op;
    logic signed [W-1:0]  s1_a, s1_b, s1_ca, s1_cb, s1_e;

    logic signed [PW-1:0] pa, pb;
    logic                 s2_valid;
    alu_op_e              s2_op;
    logic signed [PW-1:0] s2_pa, s2_pb;
    logic signed [W-1:0]  s2_a, s2_e;

    logic                 s3_valid;
    logic signed [W-1:0]  s3_result;
    logic                 s3_sat;

    logic                 out_valid_q;
    logic signed [W-1:0]  out_result_q;
    logic                 out_sat_q;

    logic signed [W-1:0]  acc;
    logic signed [SW-1:0] y;
    clamp_t               clamp;
    logic signed [W-1:0]  y_res;
    logic                 y_sat;
    logic                 unused_clamp_hi;

    // One global stall freezes every stage, so nothing can be overwritten or dropped.
    assign stall         = out_valid_q & ~bus.out_ready;
    assign adv           = ~stall;
    assign bus.in_ready  = adv;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = out_result_q;
    assign bus.sat       = out_sat_q;

    alu_pipe_scale_mult #(.W(W)) u_mult_a (.x(s1_a), .c(s1_ca), .p(pa));
    alu_pipe_scale_mult #(.W(W)) u_mult_b (.x(s1_b), .c(s1_cb), .p(pb));

    always_comb begin
        y = '0;
        case (s2_op)
            OP_LIN:  y = SW'(s2_pa) + SW'(s2_pb) + SW'(s2_e);
            OP_ADD:  y = SW'(s2_a) + SW'(s2_e);
            OP_ACC:  y = SW'(s2_pa) + SW'(s2_pb) + SW'(acc);
            OP_CLR:  y = SW'(s2_e);
            default: y = '0;
        endcase
        clamp = sat_clamp(CLAMP_W'(y), W, SAT_EN);
        y_res = clamp.val[W-1:0];
        y_sat = clamp.sat;
    end

    assign unused_clamp_hi = ^clamp.val[CLAMP_W-1:W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid     <= 1'b0;
            s1_op        <= OP_LIN;
            s1_a         <= '0;
            s1_b         <= '0;
            s1_ca        <= '0;
            s1_cb        <= '0;
            s1_e         <= '0;
            s2_valid     <= 1'b0;
            s2_op        <= OP_LIN;
            s2_pa        <= '0;
            s2_pb        <= '0;
            s2_a         <= '0;
            s2_e         <= '0;
            s3_valid     <= 1'b0;
            s3_result    <= '0;
            s3_sat       <= 1'b0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_sat_q    <= 1'b0;
        end else if (adv) begin
            s1_valid     <= bus.in_valid;
            s1_op        <= alu_op_e'(bus.op);
            s1_a         <= bus.a;
            s1_b         <= bus.b;
            s1_ca        <= bus.ca;
            s1_cb        <= bus.cb;
            s1_e         <= bus.e;
            s2_valid     <= s1_valid;
            s2_op        <= s1_op;
            s2_pa        <= pa;
            s2_pb        <= pb;
            s2_a         <= s1_a;
            s2_e         <= s1_e;
            s3_valid     <= s2_valid;
            s3_result    <= y_res;
            s3_sat       <= y_sat;
            out_valid_q  <= s3_valid;
            out_result_q <= s3_result;
            out_sat_q    <= s3_sat;
        end
    end

    // Read and written at the same stage, so back-to-back ACC ops chain without bubbles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (adv && s2_valid && (s2_op == OP_ACC || s2_op == OP_CLR)) begin
            acc <= y_res;
        end
    end
endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - scoreboard bench running clamping and wrapping alu_pipe instances in lockstep
module tb_alu_pipe;
    import alu_pipe_pkg::*;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    logic [8:0] q1[$];
    logic [8:0] q0[$];
    logic [8:0] exp1;
    logic [8:0] exp0;
    logic [7:0] snap;

    alu_pipe_if #(.W(8)) bus_s ();
    alu_pipe_if #(.W(8)) bus_w ();

    alu_pipe #(.BUS_WIDTH(8), .SAT_EN(1'b1)) u_sat  (.clk(clk), .rst(rst), .bus(bus_s));
    alu_pipe #(.BUS_WIDTH(8), .SAT_EN(1'b0)) u_wrap (.clk(clk), .rst(rst), .bus(bus_w));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && bus_s.out_valid && bus_s.out_ready) begin
            if (q1.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sat_unexpected actual=%0h required=none", bus_s.result);
            end else begin
                exp1 = q1.pop_front();
                chk("sat_result", bus_s.result, exp1[7:0]);
                chk("sat_flag", {7'd0, bus_s.sat}, {7'd0, exp1[8]});
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && bus_w.out_valid && bus_w.out_ready) begin
            if (q0.size() == 0) begin
                total++;
                bad++;
                $display("FAIL wrap_unexpected actual=%0h required=none", bus_w.result);
            end else begin
                exp0 = q0.pop_front();
                chk("wrap_result", bus_w.result, exp0[7:0]);
                chk("wrap_flag", {7'd0, bus_w.sat}, {7'd0, exp0[8]});
            end
        end
    end

    task automatic set_ready(input logic r);
        bus_s.out_ready = r;
        bus_w.out_ready = r;
    endtask

    task automatic idle();
        bus_s.in_valid = 1'b0;
        bus_w.in_valid = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [1:0] op, input logic [7:0] a, input logic [7:0] ca,
                        input logic [7:0] b, input logic [7:0] cb, input logic [7:0] e,
                        input logic push, input logic [7:0] r1, input logic s1,
                        input logic [7:0] r0, input logic s0);
        int n;
        bus_s.in_valid = 1'b1; bus_s.op = op; bus_s.a = a; bus_s.ca = ca;
        bus_s.b = b; bus_s.cb = cb; bus_s.e = e;
        bus_w.in_valid = 1'b1; bus_w.op = op; bus_w.a = a; bus_w.ca = ca;
        bus_w.b = b; bus_w.cb = cb; bus_w.e = e;
        n = 0;
        while (!bus_s.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            total++;
            bad++;
            $display("FAIL accept_timeout actual=stalled required=in_ready");
        end
        @(posedge clk);
        if (push) begin
            q1.push_back({s1, r1});
            q0.push_back({s0, r0});
        end
        @(negedge clk);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q1.size() != 0 || q0.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain_sat", 8'(q1.size()), 8'd0);
        chk("drain_wrap", 8'(q0.size()), 8'd0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        idle();
        set_ready(1'b1);
        bus_s.op = 2'b00; bus_s.a = '0; bus_s.b = '0; bus_s.ca = '0; bus_s.cb = '0; bus_s.e = '0;
        bus_w.op = 2'b00; bus_w.a = '0; bus_w.b = '0; bus_w.ca = '0; bus_w.cb = '0; bus_w.e = '0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", {7'd0, bus_s.out_valid}, 8'd0);
        chk("rst_result", bus_s.result, 8'd0);
        chk("rst_sat", {7'd0, bus_s.sat}, 8'd0);
        chk("rst_acc", u_sat.acc, 8'd0);
        chk("rst_wrap_out_valid", {7'd0, bus_w.out_valid}, 8'd0);
        rst = 1'b0;
        @(negedge clk);

        // LIN basic and exact three-cycle latency
        send(OP_LIN, 8'd10, 8'h40, 8'hFC, 8'h20, 8'd3, 1'b1, 8'd7, 1'b0, 8'd7, 1'b0);
        idle();
        chk("lat_edge1", {7'd0, bus_s.out_valid}, 8'd0);
        @(negedge clk);
        chk("lat_edge2", {7'd0, bus_s.out_valid}, 8'd0);
        @(negedge clk);
        chk("lat_edge3", {7'd0, bus_s.out_valid}, 8'd0);
        @(negedge clk);
        chk("lat_edge4", {7'd0, bus_s.out_valid}, 8'd1);
        drain();

        // saturation, wrap, floor rounding and ADD bypass
        send(OP_LIN, 8'd127, 8'h7F, 8'd127, 8'h7F, 8'd100, 1'b1, 8'h7F, 1'b1, 8'h60, 1'b1);
        send(OP_LIN, 8'hFD, 8'h40, 8'h00, 8'h00, 8'h00, 1'b1, 8'hFE, 1'b0, 8'hFE, 1'b0);
        send(OP_LIN, 8'h80, 8'h80, 8'h00, 8'h00, 8'h00, 1'b1, 8'h7F, 1'b1, 8'h80, 1'b1);
        send(OP_LIN, 8'h80, 8'h7F, 8'h80, 8'h7F, 8'h80, 1'b1, 8'h80, 1'b1, 8'h82, 1'b1);
        send(OP_ADD, 8'd100, 8'h7F, 8'h00, 8'h00, 8'd50, 1'b1, 8'h7F, 1'b1, 8'h96, 1'b1);
        send(OP_ADD, 8'hFB, 8'h7F, 8'h11, 8'h7F, 8'd3, 1'b1, 8'hFE, 1'b0, 8'hFE, 1'b0);
        idle();
        drain();

        // accumulator chain
        send(OP_CLR, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 8'd0, 1'b0, 8'd0, 1'b0);
        send(OP_ACC, 8'd16, 8'h40, 8'h00, 8'h00, 8'h00, 1'b1, 8'd8, 1'b0, 8'd8, 1'b0);
        send(OP_ACC, 8'd16, 8'h40, 8'h00, 8'h00, 8'h00, 1'b1, 8'd16, 1'b0, 8'd16, 1'b0);
        send(OP_ACC, 8'd16, 8'h40, 8'h00, 8'h00, 8'h00, 1'b1, 8'd24, 1'b0, 8'd24, 1'b0);
        send(OP_ACC, 8'd16, 8'h40, 8'h00, 8'h00, 8'h00, 1'b1, 8'd32, 1'b0, 8'd32, 1'b0);
        idle();
        drain();

        // backpressure mid-stream; result k is 5k + k
        fork
            begin
                for (int k = 1; k <= 6; k++) begin
                    send(OP_LIN, 8'(10 * k), 8'h40, 8'h00, 8'h00, 8'(k), 1'b1,
                         8'(6 * k), 1'b0, 8'(6 * k), 1'b0);
                end
                idle();
            end
            begin
                repeat (3) @(negedge clk);
                @(posedge clk);
                #1 set_ready(1'b0);
                @(negedge clk);
                snap = bus_s.result;
                chk("stall_in_ready", {7'd0, bus_s.in_ready}, 8'd0);
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk);
                    chk("stall_in_ready", {7'd0, bus_s.in_ready}, 8'd0);
                    chk("stall_out_valid", {7'd0, bus_s.out_valid}, 8'd1);
                    chk("stall_result", bus_s.result, snap);
                end
                @(posedge clk);
                #1 set_ready(1'b1);
            end
        join
        drain();

        // reset with operations in flight and acc at 24
        send(OP_CLR, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 8'd0, 1'b0, 8'd0, 1'b0);
        send(OP_ACC, 8'd16, 8'h40, 8'h00, 8'h00, 8'h00, 1'b1, 8'd8, 1'b0, 8'd8, 1'b0);
        send(OP_ACC, 8'd16, 8'h40, 8'h00, 8'h00, 8'h00, 1'b1, 8'd16, 1'b0, 8'd16, 1'b0);
        send(OP_ACC, 8'd16, 8'h40, 8'h00, 8'h00, 8'h00, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0);
        send(OP_ACC, 8'd16, 8'h40, 8'h00, 8'h00, 8'h00, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0);
        send(OP_ACC, 8'd16, 8'h40, 8'h00, 8'h00, 8'h00, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0);
        chk("pre_rst_acc", u_sat.acc, 8'd24);
        #2;
        idle();
        rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", {7'd0, bus_s.out_valid}, 8'd0);
        chk("mid_rst_acc", u_sat.acc, 8'd0);
        chk("mid_rst_wrap_acc", u_wrap.acc, 8'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("post_rst_out_valid", {7'd0, bus_s.out_valid}, 8'd0);
        chk("post_rst_queue", 8'(q1.size()), 8'd0);
        send(OP_ACC, 8'd16, 8'h40, 8'h00, 8'h00, 8'h00, 1'b1, 8'd8, 1'b0, 8'd8, 1'b0);
        idle();
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
